// File: rtl/spi_slave_frontend.sv
// Mode-0 SPI slave front end: oversamples the host pins in the clk domain and bridges
// bytes to/from valid/ready streams, plus rw synchronisation and a registered intr.
`timescale 1ns/1ps

module spi_slave_frontend #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  DEFAULT_TX  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic       rw,
    output logic       intr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       rw_sync,
    input  logic       intr_req,
    output logic       busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Pin synchroniser chain, one 4-bit word per stage: {rw, mosi, cs, sck}.
    localparam logic [3:0] SYNC_RST = 4'b0010;

    logic [3:0] sync_q [SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q[gi] <= SYNC_RST;
                end else if (gi == 0) begin
                    sync_q[gi] <= {rw, mosi, cs, sck};
                end else begin
                    sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    logic sck_s, cs_s, mosi_s, rw_s;
    assign sck_s  = sync_q[SYNC_STAGES-1][0];
    assign cs_s   = sync_q[SYNC_STAGES-1][1];
    assign mosi_s = sync_q[SYNC_STAGES-1][2];
    assign rw_s   = sync_q[SYNC_STAGES-1][3];

    state_t     state_q, state_d;
    logic       sck_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       miso_q, miso_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       intr_q;

    logic sck_rise, sck_fall, load_tx, byte_done;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = 1'b0;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        tx_underrun_d = 1'b0;
        load_tx       = 1'b0;
        byte_done     = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                miso_d    = 1'b0;
                if (!cs_s) begin
                    state_d = ACTIVE;
                    load_tx = 1'b1;
                end
            end
            ACTIVE: begin
                // cs release wins over any sck edge seen in the same cycle
                if (cs_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    miso_d    = 1'b0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    byte_done  = (bit_cnt_q == 3'd7);
                end else if (sck_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        miso_d     = tx_shift_q[6];
                    end else begin
                        load_tx = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A reload decides on the pre-write holding state; a same-cycle write stays pending.
        if (load_tx) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                miso_d      = hold_q[7];
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d    = DEFAULT_TX;
                miso_d        = DEFAULT_TX[7];
                tx_underrun_d = 1'b1;
            end
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (byte_done) begin
            if (rx_valid_q && !rx_ready) begin
                rx_overrun_d = 1'b1;
            end else begin
                rx_data_d  = {rx_shift_q[6:0], mosi_s};
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sck_prev_q    <= 1'b0;
            bit_cnt_q     <= 3'd0;
            rx_shift_q    <= 8'h00;
            tx_shift_q    <= 8'h00;
            miso_q        <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            hold_q        <= 8'h00;
            hold_full_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
            intr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sck_prev_q    <= sck_s;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            tx_underrun_q <= tx_underrun_d;
            intr_q        <= intr_req;
        end
    end

    assign miso        = miso_q;
    assign intr        = intr_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = tx_underrun_q;
    assign rw_sync     = rw_s;
    assign busy        = ~cs_s;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: a behavioural mode-0 host at clk/16 and
// negedge monitors for rx pulses, underrun and overrun events.
`timescale 1ns/1ps

module tb_spi_slave_frontend;

    logic       clk = 1'b0;
    logic       rst, sck, cs, mosi, miso, rw, intr;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, rx_overrun;
    logic       tx_valid, tx_ready, tx_underrun;
    logic       rw_sync, intr_req, busy;

    always #5 clk = ~clk;

    spi_slave_frontend #(.SYNC_STAGES(2), .DEFAULT_TX(8'h00)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
        .rw(rw), .intr(intr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_overrun(rx_overrun), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
        .rw_sync(rw_sync), .intr_req(intr_req), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    int         valid_cycles = 0;
    int         rx_pulses    = 0;
    int         und_cnt      = 0;
    int         ovr_cnt      = 0;
    logic [7:0] rx_log [$];
    logic       valid_prev   = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && !valid_prev) begin
                rx_pulses++;
                rx_log.push_back(rx_data);
            end
            if (tx_underrun) und_cnt++;
            if (rx_overrun)  ovr_cnt++;
        end
        valid_prev = rx_valid;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2ns after a falling edge so they never race the monitors.
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_clk(8);
    endtask

    // Release cs while sck is still high, so no trailing fall reaches the slave.
    task automatic cs_high();
        cs = 1'b1;
        wait_clk(8);
        sck = 1'b0;
        wait_clk(8);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sck  = 1'b0;
            mosi = b[i];
            wait_clk(8);
            got[i] = miso;
            sck = 1'b1;
            wait_clk(8);
        end
        $display("spi %0d bits: mosi=%02h miso=%02h", nbits, b, got);
    endtask

    logic [7:0] g1, g2;
    int v0, p0, u0, o0;

    initial begin
        rst = 1'b1; cs = 1'b0; sck = 1'b0; mosi = 1'b0; rw = 1'b0;
        rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; intr_req = 1'b0;

        // Reset held while the host is active
        for (int i = 0; i < 3; i++) begin
            wait_clk(1);
            sck = ~sck;
        end
        wait_clk(1);
        check_val("rst_miso", miso, 0);
        check_val("rst_intr", intr, 0);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_rx_overrun", rx_overrun, 0);
        check_val("rst_tx_ready", tx_ready, 1);
        check_val("rst_tx_underrun", tx_underrun, 0);
        check_val("rst_rw_sync", rw_sync, 0);
        check_val("rst_busy", busy, 0);
        cs = 1'b1; sck = 1'b0; rst = 1'b0;
        wait_clk(8);
        check_val("idle_busy", busy, 0);

        // Preloaded A5 out, 3C in
        rx_ready = 1'b1;
        tx_data = 8'hA5; tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check_val("tx_ready_after_write", tx_ready, 0);
        v0 = valid_cycles; p0 = rx_pulses; u0 = und_cnt;
        cs_low();
        check_val("busy_active", busy, 1);
        check_val("tx_ready_after_load", tx_ready, 1);
        spi_bits(8'h3C, 8, g1);
        cs_high();
        check_val("miso_byte_A5", g1, 8'hA5);
        check_val("rx_data_3C", rx_data, 8'h3C);
        check_val("rx_valid_cycles_1", valid_cycles - v0, 1);
        check_val("rx_pulses_1", rx_pulses - p0, 1);
        check_val("no_underrun", und_cnt - u0, 0);
        check_val("busy_after_cs", busy, 0);
        check_val("miso_idle", miso, 0);

        // Empty holding, consumer stalled across two bytes
        rx_ready = 1'b0;
        u0 = und_cnt; o0 = ovr_cnt;
        cs_low();
        spi_bits(8'h11, 8, g1);
        spi_bits(8'h22, 8, g2);
        cs_high();
        check_val("miso_default_1", g1, 8'h00);
        check_val("miso_default_2", g2, 8'h00);
        check_val("underrun_pulses", und_cnt - u0, 2);
        check_val("overrun_pulses", ovr_cnt - o0, 1);
        check_val("rx_held_valid", rx_valid, 1);
        check_val("rx_held_data", rx_data, 8'h11);
        wait_clk(1);
        rx_ready = 1'b1;
        wait_clk(1);
        check_val("rx_valid_drop", rx_valid, 0);

        // Aborted partial byte, then a clean one
        p0 = rx_pulses;
        cs_low();
        spi_bits(8'hAB, 5, g1);
        cs_high();
        check_val("partial_no_valid", rx_pulses - p0, 0);
        check_val("partial_busy", busy, 0);
        cs_low();
        spi_bits(8'hF0, 8, g1);
        cs_high();
        check_val("after_abort_pulses", rx_pulses - p0, 1);
        check_val("after_abort_data", rx_log[rx_log.size()-1], 8'hF0);

        // Back-to-back bytes with rx_ready held
        p0 = rx_pulses; v0 = valid_cycles; o0 = ovr_cnt;
        cs_low();
        spi_bits(8'h01, 8, g1);
        spi_bits(8'h02, 8, g2);
        cs_high();
        check_val("b2b_pulses", rx_pulses - p0, 2);
        check_val("b2b_cycles", valid_cycles - v0, 2);
        check_val("b2b_first", rx_log[rx_log.size()-2], 8'h01);
        check_val("b2b_second", rx_log[rx_log.size()-1], 8'h02);
        check_val("b2b_no_overrun", ovr_cnt - o0, 0);

        // intr latency and rw synchroniser depth
        intr_req = 1'b1;
        check_val("intr_before_edge", intr, 0);
        wait_clk(1);
        check_val("intr_set", intr, 1);
        intr_req = 1'b0;
        wait_clk(1);
        check_val("intr_clear", intr, 0);
        rw = 1'b1;
        wait_clk(1);
        check_val("rw_sync_stage1", rw_sync, 0);
        wait_clk(1);
        check_val("rw_sync_stage2", rw_sync, 1);
        rw = 1'b0;
        wait_clk(2);
        check_val("rw_sync_fall", rw_sync, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
